scene_compositor: RTL and testbench

Parametrised pixel compositor for the runner game's VGA path, successor to the fixed-layout scene renderer. Takes the scan position from the VGA timing block, drives address ports into external ROMs for the ground strip, top window banner and game-over text, and merges the returned pixels into one 12-bit RGB value. Ground scrolling uses a game-tick enable with speed ramp-up, and offsets are committed only at frame start to avoid tearing. Output feeds the sprite mixer one pipeline depth later than the scan position.

---
 rtl/scene_compositor.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_scene_compositor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/scene_compositor.sv
// scene_compositor
//   Pixel compositor for the runner game's VGA path. Turns the scan position
//   into addresses for the external ground, window-banner, game-over and
//   cloud ROMs, then merges the returned pixels into one 12-bit RGB value.
//   Ground scrolling advances on game ticks, with a speed ramp-up. Offsets
//   are committed only on frame_start, so a frame never tears.
//
//   Optional feature: define SCENE_PARALLAX_EN to enable the cloud layer.
//   The cloud layer has its own half-speed scroll offset. Without the macro,
//   cloud_addr is tied to 0 and cloud_pix is ignored.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   tick         one-cycle game-tick enable (100 Hz)
//   frame_start  one-cycle pulse before the first visible pixel of a frame
//   game_state   0 INITIAL, 1 PLAYING, 2/3 OVER
//   x, y         scan position; in_valid marks a visible pixel
//   *_addr       ROM addresses, valid 1 cycle after the scan position
//   *_pix        ROM data, returned ROM_LAT cycles after the address
//   data         composited pixel, ROM_LAT+2 cycles after the scan position
//   out_valid    qualifier for data (data is 0 whenever out_valid is 0)
//   speed        current scroll speed in pixels per tick
module scene_compositor #(
  parameter int          SCREEN_W    = 640,
  parameter int          GROUND_W    = 1200,
  parameter int          GROUND_Y    = 20,
  parameter int          GROUND_H    = 15,
  parameter int          WIN_X       = 0,
  parameter int          WIN_Y       = 1,
  parameter int          WIN_W       = 640,
  parameter int          WIN_H       = 153,
  parameter int          GO_X        = 223,
  parameter int          GO_Y        = 200,
  parameter int          GO_W        = 193,
  parameter int          GO_H        = 13,
  parameter int          SPEED_INIT  = 3,
  parameter int          SPEED_MAX   = 8,
  parameter int          ACCEL_TICKS = 500,
  parameter int          ROM_LAT     = 1,
  parameter int          ADDR_W      = 17,
  parameter logic [11:0] BG_COLOR    = 12'hFFF,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              frame_start,
  input  logic [1:0]        game_state,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] ground_addr,
  output logic [ADDR_W-1:0] win_addr,
  output logic [ADDR_W-1:0] go_addr,
  output logic [ADDR_W-1:0] cloud_addr,
  input  logic [11:0]       ground_pix,
  input  logic [11:0]       win_pix,
  input  logic [11:0]       go_pix,
  input  logic [11:0]       cloud_pix,
  output logic [11:0]       data,
  output logic              out_valid,
  output logic [3:0]        speed
);

  localparam int OFF_W  = $clog2(GROUND_W);
  localparam int SUM_W  = OFF_W + 1;
  localparam int GX_W   = ((OFF_W > 10) ? OFF_W : 10) + 1;
  localparam int ACC_W  = $clog2(ACCEL_TICKS + 1);
  localparam int FLAG_W = 7;

  localparam logic [3:0]       SPEED_INIT_4 = 4'(SPEED_INIT);
  localparam logic [3:0]       SPEED_MAX_4  = 4'(SPEED_MAX);
  localparam logic [ACC_W-1:0] ACC_LAST     = ACC_W'(ACCEL_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} scroll_state_t;

  scroll_state_t    state_reg, state_next;
  logic [OFF_W-1:0] pending_reg, pending_next;
  logic [OFF_W-1:0] committed_reg, committed_next;
  logic [3:0]       speed_reg, speed_next;
  logic [ACC_W-1:0] accel_reg, accel_next;

  // Advance an offset by step and wrap it modulo GROUND_W.
  // This assumes step < GROUND_W.
  function automatic logic [OFF_W-1:0] wrap_add(input logic [OFF_W-1:0] a,
                                                input logic [3:0] step);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(step);
    if (s >= SUM_W'(GROUND_W)) s = s - SUM_W'(GROUND_W);
    return s[OFF_W-1:0];
  endfunction

`ifdef SCENE_PARALLAX_EN
  logic [OFF_W-1:0] cloud_pending_reg, cloud_pending_next;
  logic [OFF_W-1:0] cloud_committed_reg, cloud_committed_next;
  logic [3:0]       cloud_step;
  // The clouds move at half the ground speed, but never stop.
  assign cloud_step = (speed_reg[3:1] == 3'd0) ? 4'd1 : {1'b0, speed_reg[3:1]};
`endif

  // ---------------- scroll FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pending_reg   <= '0;
      committed_reg <= '0;
      speed_reg     <= SPEED_INIT_4;
      accel_reg     <= '0;
`ifdef SCENE_PARALLAX_EN
      cloud_pending_reg   <= '0;
      cloud_committed_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      committed_reg <= committed_next;
      speed_reg     <= speed_next;
      accel_reg     <= accel_next;
`ifdef SCENE_PARALLAX_EN
      cloud_pending_reg   <= cloud_pending_next;
      cloud_committed_reg <= cloud_committed_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    committed_next = committed_reg;
    speed_next     = speed_reg;
    accel_next     = accel_reg;
`ifdef SCENE_PARALLAX_EN
    cloud_pending_next   = cloud_pending_reg;
    cloud_committed_next = cloud_committed_reg;
`endif
    case (game_state)
      2'd0:    state_next = S_IDLE;
      2'd1:    state_next = S_RUN;
      default: state_next = S_FROZEN;
    endcase

    // The commit samples the pre-tick pending value when both events coincide.
    if (frame_start) begin
      committed_next = pending_reg;
`ifdef SCENE_PARALLAX_EN
      cloud_committed_next = cloud_pending_reg;
`endif
    end

    case (state_next)
      S_IDLE: begin
        pending_next   = '0;
        committed_next = '0;
        speed_next     = SPEED_INIT_4;
        accel_next     = '0;
`ifdef SCENE_PARALLAX_EN
        cloud_pending_next   = '0;
        cloud_committed_next = '0;
`endif
      end
      S_RUN: begin
        if (tick) begin
          pending_next = wrap_add(pending_reg, speed_reg);
`ifdef SCENE_PARALLAX_EN
          cloud_pending_next = wrap_add(cloud_pending_reg, cloud_step);
`endif
          if (accel_reg == ACC_LAST) begin
            accel_next = '0;
            if (speed_reg < SPEED_MAX_4) speed_next = speed_reg + 4'd1;
          end else begin
            accel_next = accel_reg + ACC_W'(1);
          end
        end
      end
      default: ;  // FROZEN holds everything
    endcase
  end

  assign speed = speed_reg;

  // ---------------- stage 1: region tests and ROM addresses ----------------
  logic [10:0] xe;
  logic [9:0]  ye;
  logic [10:0] win_dx, go_dx;
  logic [9:0]  win_dy, go_dy, gnd_dy, gnd_row;
  logic        in_win, in_go, in_ground, in_cloud, vis;
  logic [GX_W-1:0] gx_sum, gx;

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  // Unsigned offsets wrap to large values left of or above a box.
  // That lets one compare per axis serve as the inside test.
  assign win_dx = xe - 11'(WIN_X);
  assign win_dy = ye - 10'(WIN_Y);
  assign go_dx  = xe - 11'(GO_X);
  assign go_dy  = ye - 10'(GO_Y);
  assign gnd_dy = ye - 10'(GROUND_Y);

  assign in_win    = (win_dx < 11'(WIN_W)) && (win_dy < 10'(WIN_H));
  assign in_go     = (go_dx < 11'(GO_W)) && (go_dy < 10'(GO_H));
  assign in_ground = gnd_dy < 10'(GROUND_H);
  assign in_cloud  = ye < 10'(GROUND_Y);
  assign vis       = in_valid && (xe < 11'(SCREEN_W));
  assign gnd_row   = in_ground ? gnd_dy : 10'd0;

  assign gx_sum = GX_W'(x) + GX_W'(committed_reg);
  assign gx     = (gx_sum >= GX_W'(GROUND_W)) ? gx_sum - GX_W'(GROUND_W) : gx_sum;

  logic [ADDR_W-1:0] ground_addr_reg, win_addr_reg, go_addr_reg;
  logic [FLAG_W-1:0] flags_s1_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ground_addr_reg <= '0;
      win_addr_reg    <= '0;
      go_addr_reg     <= '0;
      flags_s1_reg    <= '0;
    end else begin
      ground_addr_reg <= ADDR_W'(gnd_row) * ADDR_W'(GROUND_W) + ADDR_W'(gx);
      win_addr_reg    <= ADDR_W'(win_dy) * ADDR_W'(WIN_W) + ADDR_W'(win_dx);
      go_addr_reg     <= ADDR_W'(go_dy) * ADDR_W'(GO_W) + ADDR_W'(go_dx);
      flags_s1_reg    <= {vis, game_state[1], (game_state == 2'd0),
                          in_win, in_go, in_ground, in_cloud};
    end
  end

  assign ground_addr = ground_addr_reg;
  assign win_addr    = win_addr_reg;
  assign go_addr     = go_addr_reg;

`ifdef SCENE_PARALLAX_EN
  logic [ADDR_W-1:0] cloud_addr_reg;
  logic [GX_W-1:0]   cx_sum, cx;
  assign cx_sum = GX_W'(x) + GX_W'(cloud_committed_reg);
  assign cx     = (cx_sum >= GX_W'(GROUND_W)) ? cx_sum - GX_W'(GROUND_W) : cx_sum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cloud_addr_reg <= '0;
    else     cloud_addr_reg <= ADDR_W'(in_cloud ? ye : 10'd0) * ADDR_W'(GROUND_W) + ADDR_W'(cx);
  end
  assign cloud_addr = cloud_addr_reg;
`else
  assign cloud_addr = '0;
`endif

  // ---------------- flag delay matching the ROM latency ----------------
  genvar gi;
  for (gi = 0; gi < ROM_LAT; gi++) begin : g_dly
    logic [FLAG_W-1:0] flags_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_reg <= '0;
        else     flags_reg <= flags_s1_reg;
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_reg <= '0;
        else     flags_reg <= g_dly[gi-1].flags_reg;
      end
    end
  end

  logic f_valid, f_over, f_init, f_win, f_go, f_ground, f_cloud;
  assign {f_valid, f_over, f_init, f_win, f_go, f_ground, f_cloud} =
         g_dly[ROM_LAT-1].flags_reg;

  // ---------------- output stage: layer priority ----------------
  logic [11:0] data_reg, data_next;
  logic        out_valid_reg;

`ifndef SCENE_PARALLAX_EN
  logic cloud_unused;
  assign cloud_unused = (^cloud_pix) ^ f_cloud;
`endif

  // Layers are applied lowest priority first, so each later hit overrides.
  always_comb begin
    data_next = BG_COLOR;
`ifdef SCENE_PARALLAX_EN
    if (f_cloud && (cloud_pix != KEY_COLOR)) data_next = cloud_pix;
`endif
    if (f_ground && !f_init)                       data_next = ground_pix;
    if (f_over && f_go && (go_pix != KEY_COLOR))   data_next = go_pix;
    if (f_win)                                     data_next = win_pix;
    if (!f_valid)                                  data_next = 12'h000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg      <= 12'h000;
      out_valid_reg <= 1'b0;
    end else begin
      data_reg      <= data_next;
      out_valid_reg <= f_valid;
    end
  end

  assign data      = data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_scene_compositor.sv
// tb_scene_compositor
//   Directed bench for scene_compositor. The ROM models have a 1-cycle read.
//   The ground and banner ROMs return the low 12 bits of their address.
//   The game-over ROM returns a value the stimulus sets. The banner is
//   narrowed to 200 px so that the ground band is reachable.
module tb_scene_compositor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  game_state = 2'd0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        in_valid = 1'b0;
  logic [16:0] ground_addr, win_addr, go_addr, cloud_addr;
  logic [11:0] ground_pix = '0, win_pix = '0, go_pix = '0, cloud_pix = '0;
  logic [11:0] data;
  logic        out_valid;
  logic [3:0]  speed;
  logic [11:0] go_rom_val = 12'hF0F;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scene_compositor #(.WIN_W(200)) dut (
    .clk(clk), .rst(rst), .tick(tick), .frame_start(frame_start),
    .game_state(game_state), .x(x), .y(y), .in_valid(in_valid),
    .ground_addr(ground_addr), .win_addr(win_addr), .go_addr(go_addr),
    .cloud_addr(cloud_addr), .ground_pix(ground_pix), .win_pix(win_pix),
    .go_pix(go_pix), .cloud_pix(cloud_pix), .data(data),
    .out_valid(out_valid), .speed(speed)
  );

  always @(posedge clk) begin
    ground_pix <= ground_addr[11:0];
    win_pix    <= win_addr[11:0];
    go_pix     <= go_rom_val;
    cloud_pix  <= 12'h0F0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel. Check that out_valid stays low (with data 0) one cycle
  // before the expected latency, then check the composited value at
  // exactly 3 cycles.
  task automatic pix(input string tag, input logic [9:0] px, input logic [8:0] py,
                     input logic [11:0] exp);
    @(negedge clk); x = px; y = py; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early_v"}, out_valid, 0);
    chk({tag, "_early_d"}, data, 0);
    @(negedge clk);
    chk({tag, "_v"}, out_valid, 1);
    chk({tag, "_d"}, data, exp);
  endtask

  // Present one pixel and leave the registered addresses for inspection.
  task automatic present(input logic [9:0] px, input logic [8:0] py);
    @(negedge clk); x = px; y = py; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    @(negedge clk); tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_speed", speed, 3);
    chk("rst_gaddr", ground_addr, 0);
    chk("rst_waddr", win_addr, 0);
    chk("rst_caddr", cloud_addr, 0);
    @(negedge clk); rst = 1'b0;

    // ---- INITIAL: ground suppressed, banner visible ----
    pix("init_gnd", 300, 25, 12'hFFF);
    pix("init_win", 50, 10, 12'h73A);
    chk("init_speed", speed, 3);

    // ---- PLAYING, offset 0 ----
    game_state = 2'd1;
    pix("play_gnd", 300, 25, 12'h89C);
    pix("play_gnd_last", 300, 34, 12'h2CC);
    pix("play_below", 300, 35, 12'hFFF);
    pix("play_above", 300, 19, 12'hFFF);
    pix("win_right_edge", 199, 10, 12'h7CF);
    pix("win_outside", 200, 10, 12'hFFF);
    go_rom_val = 12'h000;
    pix("go_not_over", 300, 205, 12'hFFF);
    present(300, 205);
    chk("go_addr", go_addr, 1042);
    present(50, 10);
    chk("win_addr", win_addr, 1850);
    present(300, 25);
    chk("gnd_addr", ground_addr, 6300);

    // in_valid low: data and out_valid stay low at the matching cycle
    @(negedge clk); x = 10'd300; y = 9'd25; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("invalid_v", out_valid, 0);
    chk("invalid_d", data, 0);

    // ---- 400 ticks, commit after each: 3, 6, ..., 1197, 0 ----
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0; frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0; x = 10'd0; y = 9'd20; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      chk($sformatf("commit_%0d", i), ground_addr, (3 * i) % 1200);
      if (i == 399) begin
        present(10, 20);
        chk("gx_wrap", ground_addr, 7);
      end
    end

    // ---- speed ramp ----
    ticks(99);
    chk("speed_499", speed, 3);
    ticks(1);
    chk("speed_500", speed, 4);
    ticks(1999);
    chk("speed_2499", speed, 7);
    ticks(1);
    chk("speed_2500", speed, 8);
    ticks(500);
    chk("speed_sat", speed, 8);

    // ---- back to INITIAL clears everything ----
    @(negedge clk); game_state = 2'd0;
    @(negedge clk);
    chk("idle_speed", speed, 3);
    present(0, 20);
    chk("idle_commit", ground_addr, 0);

    // ---- tick and frame_start together: pending 9 -> committed 9 ----
    @(negedge clk); game_state = 2'd1;
    ticks(3);
    present(0, 20);
    chk("no_commit_wo_fs", ground_addr, 0);
    @(negedge clk); tick = 1'b1; frame_start = 1'b1;
    @(negedge clk); tick = 1'b0; frame_start = 1'b0;
    present(0, 20);
    chk("coincide_commit", ground_addr, 9);
    commit();
    present(0, 20);
    chk("coincide_pending", ground_addr, 12);

    // ---- OVER freezes scrolling ----
    @(negedge clk); game_state = 2'd2;
    ticks(5);
    commit();
    present(0, 20);
    chk("frozen_commit", ground_addr, 12);
    chk("frozen_speed", speed, 3);
    go_rom_val = 12'hF0F;
    pix("over_go_key", 300, 205, 12'hFFF);
    go_rom_val = 12'h000;
    pix("over_go_text", 300, 205, 12'h000);
    pix("over_gnd", 300, 25, 12'h8A8);
    pix("over_win", 50, 10, 12'h73A);
    game_state = 2'd3;
    pix("state3_go", 300, 205, 12'h000);

    // ---- resume without reset ----
    @(negedge clk); game_state = 2'd1;
    ticks(1);
    commit();
    present(0, 20);
    chk("resume_commit", ground_addr, 15);

    // ---- reset mid-scan ----
    ticks(495);
    chk("pre_rst_speed", speed, 4);
    commit();
    @(negedge clk); x = 10'd300; y = 9'd25; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data", data, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_gaddr", ground_addr, 0);
    chk("mid_rst_speed", speed, 3);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    present(0, 20);
    chk("post_rst_commit", ground_addr, 0);
    pix("post_rst_gnd", 300, 25, 12'h89C);
    @(negedge clk); tick = 1'b1; frame_start = 1'b1;
    @(negedge clk); tick = 1'b0; frame_start = 1'b0;
    commit();
    present(0, 20);
    chk("post_rst_first_tick", ground_addr, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
